// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
//   - Branch condition codes carried from decode to the branch resolver.
//   - Bit positions of the adder flags inside the packed {C,Z,V,S} vector.
package mips_pkg;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_EQ   = 3'd1;
  localparam logic [2:0] BR_NE   = 3'd2;
  localparam logic [2:0] BR_LTZ  = 3'd3;
  localparam logic [2:0] BR_GEZ  = 3'd4;
  localparam logic [2:0] BR_GTZ  = 3'd5;
  localparam logic [2:0] BR_LEZ  = 3'd6;
  localparam logic [2:0] BR_RSVD = 3'd7;

  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_S = 0;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator (purely combinational).
// Ports:
//   branch_type  in   3  condition code (mips_pkg BR_*)
//   flags        in   4  adder flags {C,Z,V,S}
//   cond         out  1  condition true
// Upstream computes rs-rt for BEQ/BNE and rs+0 for the zero compares, so
// only Z and S are needed here.
module branch_cond
  import mips_pkg::*;
(
  input  logic [2:0] branch_type,
  input  logic [3:0] flags,
  output logic       cond
);

  logic z;
  logic s;
  logic unused_flags;

  assign z = flags[FLAG_Z];
  assign s = flags[FLAG_S];
  assign unused_flags = flags[FLAG_C] ^ flags[FLAG_V];

  always_comb begin
    cond = 1'b0;
    case (branch_type)
      BR_EQ:   cond = z;
      BR_NE:   cond = ~z;
      BR_LTZ:  cond = s;
      BR_GEZ:  cond = ~s;
      BR_GTZ:  cond = ~s & ~z;
      BR_LEZ:  cond = s | z;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register.
// Captures the EX adder result, flags and control bits, resolves the
// conditional branch and raises the signed-overflow trap for add/addi/sub.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   stall, flush           hold stage / load a bubble (flush wins)
//   validIn, pcIn          EX instruction valid flag and PC
//   aluResult, C/Z/V/S     adder result and flags
//   trapOnOvf              instruction traps on signed overflow
//   branchType/Target      branch condition code and target
//   storeData, writeReg    store data and destination register
//   regWrite/memRead/memWrite  control bits
//   *Out, flagsOut         registered stage contents, flags {C,Z,V,S}
//   branchTaken            registered branch decision
//   ovfException, excPc    registered overflow trap and trapping PC
module ex_mem_reg
  import mips_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      validIn,
  input  logic [DATA_WIDTH-1:0]     pcIn,
  input  logic [DATA_WIDTH-1:0]     aluResult,
  input  logic                      C,
  input  logic                      Z,
  input  logic                      V,
  input  logic                      S,
  input  logic                      trapOnOvf,
  input  logic [2:0]                branchType,
  input  logic [DATA_WIDTH-1:0]     branchTarget,
  input  logic [DATA_WIDTH-1:0]     storeData,
  input  logic [REG_ADDR_WIDTH-1:0] writeReg,
  input  logic                      regWrite,
  input  logic                      memRead,
  input  logic                      memWrite,
  output logic                      validOut,
  output logic [DATA_WIDTH-1:0]     aluResultOut,
  output logic [DATA_WIDTH-1:0]     storeDataOut,
  output logic [REG_ADDR_WIDTH-1:0] writeRegOut,
  output logic                      regWriteOut,
  output logic                      memReadOut,
  output logic                      memWriteOut,
  output logic [3:0]                flagsOut,
  output logic                      branchTaken,
  output logic [DATA_WIDTH-1:0]     branchTargetOut,
  output logic                      ovfException,
  output logic [DATA_WIDTH-1:0]     excPc
);

  logic [3:0] flags;
  logic       cond;
  logic       ovf;
  logic       live;   // valid instruction whose side effects are allowed
  logic       taken;

  assign flags = {C, Z, V, S};

  branch_cond u_branch_cond (
    .branch_type (branchType),
    .flags       (flags),
    .cond        (cond)
  );

  assign ovf   = validIn & trapOnOvf & V;
  assign live  = validIn & ~ovf;
  assign taken = live & cond;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      validOut        <= 1'b0;
      aluResultOut    <= '0;
      storeDataOut    <= '0;
      writeRegOut     <= '0;
      regWriteOut     <= 1'b0;
      memReadOut      <= 1'b0;
      memWriteOut     <= 1'b0;
      flagsOut        <= '0;
      branchTaken     <= 1'b0;
      branchTargetOut <= '0;
      ovfException    <= 1'b0;
      excPc           <= '0;
    end else if (!stall) begin
      validOut        <= validIn;
      aluResultOut    <= aluResult;
      storeDataOut    <= storeData;
      writeRegOut     <= writeReg;
      regWriteOut     <= live & regWrite;
      memReadOut      <= live & memRead;
      memWriteOut     <= live & memWrite;
      flagsOut        <= flags;
      branchTaken     <= taken;
      branchTargetOut <= branchTarget;
      ovfException    <= ovf;
      // excPc keeps the last trapping PC until another trap is captured
      if (ovf) begin
        excPc <= pcIn;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
module tb_ex_mem_reg;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, validIn;
  logic [31:0] pcIn, aluResult, branchTarget, storeData;
  logic        C, Z, V, S, trapOnOvf;
  logic [2:0]  branchType;
  logic [4:0]  writeReg;
  logic        regWrite, memRead, memWrite;
  logic        validOut;
  logic [31:0] aluResultOut, storeDataOut, branchTargetOut, excPc;
  logic [4:0]  writeRegOut;
  logic        regWriteOut, memReadOut, memWriteOut;
  logic [3:0]  flagsOut;
  logic        branchTaken, ovfException;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_reg #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .validIn(validIn), .pcIn(pcIn), .aluResult(aluResult),
    .C(C), .Z(Z), .V(V), .S(S), .trapOnOvf(trapOnOvf),
    .branchType(branchType), .branchTarget(branchTarget),
    .storeData(storeData), .writeReg(writeReg),
    .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
    .validOut(validOut), .aluResultOut(aluResultOut),
    .storeDataOut(storeDataOut), .writeRegOut(writeRegOut),
    .regWriteOut(regWriteOut), .memReadOut(memReadOut),
    .memWriteOut(memWriteOut), .flagsOut(flagsOut),
    .branchTaken(branchTaken), .branchTargetOut(branchTargetOut),
    .ovfException(ovfException), .excPc(excPc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".validOut"},        32'(validOut),        32'd0);
    check({tag, ".aluResultOut"},    aluResultOut,         32'd0);
    check({tag, ".storeDataOut"},    storeDataOut,         32'd0);
    check({tag, ".writeRegOut"},     32'(writeRegOut),     32'd0);
    check({tag, ".regWriteOut"},     32'(regWriteOut),     32'd0);
    check({tag, ".memReadOut"},      32'(memReadOut),      32'd0);
    check({tag, ".memWriteOut"},     32'(memWriteOut),     32'd0);
    check({tag, ".flagsOut"},        32'(flagsOut),        32'd0);
    check({tag, ".branchTaken"},     32'(branchTaken),     32'd0);
    check({tag, ".branchTargetOut"}, branchTargetOut,      32'd0);
    check({tag, ".ovfException"},    32'(ovfException),    32'd0);
    check({tag, ".excPc"},           excPc,                32'd0);
  endtask

  task automatic set_flags(input logic c, input logic z, input logic v, input logic s);
    C = c; Z = z; V = v; S = s;
  endtask

  initial begin
    // Reset with everything asserted, including a would-be trap
    rst_n = 1'b0; stall = 1'b1; flush = 1'b0; validIn = 1'b1;
    pcIn = 32'h0040_0010; aluResult = 32'hFFFF_FFFF;
    set_flags(1, 1, 1, 1); trapOnOvf = 1'b1;
    branchType = BR_EQ; branchTarget = 32'h0040_1000;
    storeData = 32'hA5A5_A5A5; writeReg = 5'd31;
    regWrite = 1'b1; memRead = 1'b1; memWrite = 1'b1;
    tick(); tick();
    check_zero("reset");

    // Pass-through on the first edge after release
    rst_n = 1'b1; stall = 1'b0; trapOnOvf = 1'b0;
    aluResult = 32'h0000_0010; writeReg = 5'd5; set_flags(0, 0, 0, 0);
    branchType = BR_NONE; regWrite = 1'b1; memRead = 1'b0; memWrite = 1'b0;
    storeData = 32'h1111_2222; branchTarget = 32'h0040_0200;
    tick();
    check("pass.validOut",     32'(validOut),    32'd1);
    check("pass.aluResultOut", aluResultOut,     32'h10);
    check("pass.writeRegOut",  32'(writeRegOut), 32'd5);
    check("pass.regWriteOut",  32'(regWriteOut), 32'd1);
    check("pass.flagsOut",     32'(flagsOut),    32'b0000);
    check("pass.storeDataOut", storeDataOut,     32'h1111_2222);
    check("pass.branchTaken",  32'(branchTaken), 32'd0);

    // Overflow trap: 0x7FFFFFFF + 1, BLTZ would be taken but the trap wins
    pcIn = 32'h0040_0020; aluResult = 32'h8000_0000; set_flags(0, 0, 1, 1);
    trapOnOvf = 1'b1; regWrite = 1'b1; memWrite = 1'b1; branchType = BR_LTZ;
    tick();
    check("trap.ovfException", 32'(ovfException), 32'd1);
    check("trap.excPc",        excPc,             32'h0040_0020);
    check("trap.regWriteOut",  32'(regWriteOut),  32'd0);
    check("trap.memWriteOut",  32'(memWriteOut),  32'd0);
    check("trap.branchTaken",  32'(branchTaken),  32'd0);
    check("trap.flagsOut",     32'(flagsOut),     32'b0011);
    check("trap.validOut",     32'(validOut),     32'd1);

    // Same add without trapping (addu): side effects pass, excPc holds
    pcIn = 32'h0040_0024; trapOnOvf = 1'b0; memWrite = 1'b0;
    tick();
    check("addu.ovfException", 32'(ovfException), 32'd0);
    check("addu.regWriteOut",  32'(regWriteOut),  32'd1);
    check("addu.excPc",        excPc,             32'h0040_0020);
    check("addu.branchTaken",  32'(branchTaken),  32'd1);

    // Branch table
    regWrite = 1'b0; memRead = 1'b1; branchTarget = 32'h0040_0100;
    branchType = BR_EQ; set_flags(1, 1, 0, 0);
    tick();
    check("beq.taken",      32'(branchTaken), 32'd1);
    check("beq.target",     branchTargetOut,  32'h0040_0100);
    check("beq.memReadOut", 32'(memReadOut),  32'd1);

    branchType = BR_NE; memRead = 1'b0;
    tick();
    check("bne_z1.taken", 32'(branchTaken), 32'd0);
    set_flags(0, 0, 0, 1);
    tick();
    check("bne_z0.taken", 32'(branchTaken), 32'd1);

    branchType = BR_GTZ; set_flags(0, 1, 0, 0);
    tick();
    check("bgtz_z1.taken", 32'(branchTaken), 32'd0);
    set_flags(0, 0, 0, 0);
    tick();
    check("bgtz_pos.taken", 32'(branchTaken), 32'd1);

    branchType = BR_LEZ; set_flags(0, 0, 0, 1);
    tick();
    check("blez_s1.taken", 32'(branchTaken), 32'd1);

    branchType = BR_GEZ;
    tick();
    check("bgez_s1.taken", 32'(branchTaken), 32'd0);

    branchType = BR_RSVD; set_flags(1, 1, 1, 1);
    tick();
    check("rsvd.taken", 32'(branchTaken), 32'd0);

    // Bubble from EX: no control, no branch, data still captured
    validIn = 1'b0; branchType = BR_EQ; set_flags(0, 1, 0, 0);
    regWrite = 1'b1; memRead = 1'b1; memWrite = 1'b1; aluResult = 32'h0000_0ABC;
    tick();
    check("inval.validOut",    32'(validOut),    32'd0);
    check("inval.taken",       32'(branchTaken), 32'd0);
    check("inval.regWriteOut", 32'(regWriteOut), 32'd0);
    check("inval.memWriteOut", 32'(memWriteOut), 32'd0);
    check("inval.aluResultOut", aluResultOut,    32'h0000_0ABC);

    // Taken branch that is then stalled
    validIn = 1'b1; pcIn = 32'h0040_0040; aluResult = 32'h0;
    set_flags(1, 1, 0, 0); branchType = BR_EQ; branchTarget = 32'h0040_0080;
    storeData = 32'hDEAD_BEEF; writeReg = 5'd9;
    regWrite = 1'b0; memRead = 1'b0; memWrite = 1'b1;
    tick();
    check("br.taken",    32'(branchTaken), 32'd1);
    check("br.memWrite", 32'(memWriteOut), 32'd1);

    stall = 1'b1; validIn = 1'b0; aluResult = 32'h1234_5678;
    branchType = BR_NONE; memWrite = 1'b0; storeData = 32'h0;
    trapOnOvf = 1'b1; set_flags(0, 0, 1, 0); pcIn = 32'h0BAD_0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.validOut",     32'(validOut),     32'd1);
      check("stall.taken",        32'(branchTaken),  32'd1);
      check("stall.target",       branchTargetOut,   32'h0040_0080);
      check("stall.aluResultOut", aluResultOut,      32'h0);
      check("stall.storeDataOut", storeDataOut,      32'hDEAD_BEEF);
      check("stall.memWriteOut",  32'(memWriteOut),  32'd1);
      check("stall.flagsOut",     32'(flagsOut),     32'b1100);
      check("stall.writeRegOut",  32'(writeRegOut),  32'd9);
      check("stall.excPc",        excPc,             32'h0040_0020);
      check("stall.ovf",          32'(ovfException), 32'd0);
    end

    // Flush wins over stall
    flush = 1'b1; validIn = 1'b1;
    tick();
    check_zero("flush");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
